// File: rtl/gpio_port_6502_if.sv
// CPU-side register bus of the multi-port GPIO block.
// Carries select, strobe, address, data and the interrupt line.
interface gpio_port_6502_if;
    logic       cs;
    logic       we;
    logic [4:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       irq;

    modport master (
        output cs,
        output we,
        output addr,
        output din,
        input  dout,
        input  irq
    );

    modport slave (
        input  cs,
        input  we,
        input  addr,
        input  din,
        output dout,
        output irq
    );
endinterface

// File: rtl/gpio_port_6502.sv
// Multi-port 8-bit GPIO for the 6502 SoC: per-bit direction,
// atomic set/clear, input synchronisers and sticky edge flags.
module gpio_port_6502 #(
    parameter int NPORTS      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    gpio_port_6502_if.slave       bus,
    input  logic [8*NPORTS-1:0]   gpio_i,
    output logic [8*NPORTS-1:0]   gpio_o,
    output logic [8*NPORTS-1:0]   gpio_oe
);

    localparam int W = 8 * NPORTS;

    typedef enum logic [2:0] {
        REG_OUT   = 3'd0,
        REG_DIR   = 3'd1,
        REG_IN    = 3'd2,
        REG_RISE  = 3'd3,
        REG_FALL  = 3'd4,
        REG_FLAGS = 3'd5,
        REG_SET   = 3'd6,
        REG_CLR   = 3'd7
    } reg_e;

    logic [1:0] port;
    reg_e       rsel;
    logic       wr;
    logic       rd;

    assign port = bus.addr[4:3];
    assign rsel = reg_e'(bus.addr[2:0]);
    assign wr   = bus.cs & bus.we;
    assign rd   = bus.cs & ~bus.we;

    logic [NPORTS-1:0][7:0] out_q;
    logic [NPORTS-1:0][7:0] dir_q;
    logic [NPORTS-1:0][7:0] rise_en_q;
    logic [NPORTS-1:0][7:0] fall_en_q;
    logic [NPORTS-1:0][7:0] flags_q;

    logic [NPORTS-1:0][7:0] out_d;
    logic [NPORTS-1:0][7:0] dir_d;
    logic [NPORTS-1:0][7:0] rise_en_d;
    logic [NPORTS-1:0][7:0] fall_en_d;
    logic [NPORTS-1:0][7:0] flags_d;

    logic [NPORTS-1:0][7:0] set_w;
    logic [NPORTS-1:0][7:0] clr_w;

    logic [SYNC_STAGES-1:0][W-1:0] sync_q;
    logic [W-1:0]                  prev_q;
    logic [NPORTS-1:0][7:0]        sync_b;
    logic [NPORTS-1:0][7:0]        prev_b;

    logic [NPORTS-1:0] hit;
    logic [7:0]        rdata;
    logic [7:0]        dout_q;
    logic              irq_q;

    assign sync_b = sync_q[SYNC_STAGES-1];
    assign prev_b = prev_q;

    always_comb begin
        hit = '0;
        for (int p = 0; p < NPORTS; p++) begin
            hit[p] = (port == 2'(p));
        end
    end

    // Edge detection is independent of DIR so driven pins see their own edges.
    always_comb begin
        set_w = '0;
        for (int p = 0; p < NPORTS; p++) begin
            set_w[p] = (sync_b[p] & ~prev_b[p] & rise_en_q[p])
                     | (~sync_b[p] & prev_b[p] & fall_en_q[p]);
        end
    end

    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr_w     = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (wr && hit[p]) begin
                unique case (rsel)
                    REG_OUT:   out_d[p]     = bus.din;
                    REG_DIR:   dir_d[p]     = bus.din;
                    REG_IN:    ;
                    REG_RISE:  rise_en_d[p] = bus.din;
                    REG_FALL:  fall_en_d[p] = bus.din;
                    REG_FLAGS: clr_w[p]     = bus.din;
                    REG_SET:   out_d[p]     = out_q[p] | bus.din;
                    REG_CLR:   out_d[p]     = out_q[p] & ~bus.din;
                endcase
            end
        end
    end

    // A new edge beats a simultaneous write-1-clear of the same bit.
    always_comb begin
        flags_d = '0;
        for (int p = 0; p < NPORTS; p++) begin
            flags_d[p] = (flags_q[p] & ~clr_w[p]) | set_w[p];
        end
    end

    always_comb begin
        rdata = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (hit[p]) begin
                unique case (rsel)
                    REG_OUT:   rdata = out_q[p];
                    REG_DIR:   rdata = dir_q[p];
                    REG_IN:    rdata = sync_b[p];
                    REG_RISE:  rdata = rise_en_q[p];
                    REG_FALL:  rdata = fall_en_q[p];
                    REG_FLAGS: rdata = flags_q[p];
                    REG_SET:   rdata = out_q[p];
                    REG_CLR:   rdata = out_q[p];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_q     <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            flags_q   <= '0;
            sync_q    <= '0;
            prev_q    <= '0;
            dout_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            flags_q   <= flags_d;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], gpio_i};
            prev_q    <= sync_q[SYNC_STAGES-1];
            irq_q     <= |flags_q;
            if (rd) begin
                dout_q <= rdata;
            end
        end
    end

    assign bus.dout = dout_q;
    assign bus.irq  = irq_q;
    assign gpio_o   = out_q;
    assign gpio_oe  = dir_q;

endmodule

// File: tb/tb_gpio_port_6502.sv
// Bench for gpio_port_6502: two builds (4 ports/2 stages, 1 port/3 stages)
// against a register-level reference model plus directed scenarios.
module tb_gpio_port_6502;

    logic        clk;
    logic        reset;
    logic [31:0] gpio_a_i;
    logic [31:0] gpio_a_o;
    logic [31:0] gpio_a_oe;
    logic [7:0]  gpio_b_i;
    logic [7:0]  gpio_b_o;
    logic [7:0]  gpio_b_oe;

    int n_chk;
    int n_fail;
    bit started;

    gpio_port_6502_if bus_a ();
    gpio_port_6502_if bus_b ();

    gpio_port_6502 #(.NPORTS(4), .SYNC_STAGES(2)) dut_a (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_a),
        .gpio_i  (gpio_a_i),
        .gpio_o  (gpio_a_o),
        .gpio_oe (gpio_a_oe)
    );

    gpio_port_6502 #(.NPORTS(1), .SYNC_STAGES(3)) dut_b (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_b),
        .gpio_i  (gpio_b_i),
        .gpio_o  (gpio_b_o),
        .gpio_oe (gpio_b_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state per build: register bytes and a history of pad samples.
    logic [7:0]  m_out  [2][4];
    logic [7:0]  m_dir  [2][4];
    logic [7:0]  m_ren  [2][4];
    logic [7:0]  m_fen  [2][4];
    logic [7:0]  m_flg  [2][4];
    logic [31:0] m_smp  [2][4];
    logic [7:0]  m_dout [2];
    logic        m_irq  [2];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mdl_step(input int i, input int n, input int s,
                            input logic rst, input logic cs, input logic we,
                            input logic [4:0] a, input logic [7:0] d,
                            input logic [31:0] pads);
        int p;
        int r;
        logic [7:0] sy;
        logic [7:0] pv;
        logic [7:0] clr;
        logic any;
        if (!rst) begin
            for (int q = 0; q < 4; q++) begin
                m_out[i][q] = 0;
                m_dir[i][q] = 0;
                m_ren[i][q] = 0;
                m_fen[i][q] = 0;
                m_flg[i][q] = 0;
                m_smp[i][q] = 0;
            end
            m_dout[i] = 0;
            m_irq[i]  = 0;
            return;
        end
        p = int'(a[4:3]);
        r = int'(a[2:0]);
        any = 1'b0;
        for (int q = 0; q < n; q++) any |= (m_flg[i][q] != 0);
        if (cs && !we) begin
            if (p >= n) m_dout[i] = 0;
            else begin
                case (r)
                    1: m_dout[i] = m_dir[i][p];
                    2: m_dout[i] = m_smp[i][s-1][8*p +: 8];
                    3: m_dout[i] = m_ren[i][p];
                    4: m_dout[i] = m_fen[i][p];
                    5: m_dout[i] = m_flg[i][p];
                    default: m_dout[i] = m_out[i][p];
                endcase
            end
        end
        for (int q = 0; q < n; q++) begin
            sy  = m_smp[i][s-1][8*q +: 8];
            pv  = m_smp[i][s][8*q +: 8];
            clr = (cs && we && p == q && r == 5) ? d : 8'h00;
            m_flg[i][q] = (m_flg[i][q] & ~clr)
                        | (sy & ~pv & m_ren[i][q])
                        | (~sy & pv & m_fen[i][q]);
        end
        if (cs && we && p < n) begin
            case (r)
                0: m_out[i][p] = d;
                1: m_dir[i][p] = d;
                3: m_ren[i][p] = d;
                4: m_fen[i][p] = d;
                6: m_out[i][p] = m_out[i][p] | d;
                7: m_out[i][p] = m_out[i][p] & ~d;
                default: ;
            endcase
        end
        for (int k = s; k > 0; k--) m_smp[i][k] = m_smp[i][k-1];
        m_smp[i][0] = pads;
        m_irq[i] = any;
    endtask

    function automatic logic [31:0] pack_out(input int i, input int n);
        logic [31:0] v;
        v = '0;
        for (int q = 0; q < n; q++) v[8*q +: 8] = m_out[i][q];
        return v;
    endfunction

    function automatic logic [31:0] pack_dir(input int i, input int n);
        logic [31:0] v;
        v = '0;
        for (int q = 0; q < n; q++) v[8*q +: 8] = m_dir[i][q];
        return v;
    endfunction

    always @(posedge clk) begin
        mdl_step(0, 4, 2, reset, bus_a.cs, bus_a.we, bus_a.addr, bus_a.din,
                 gpio_a_i);
        mdl_step(1, 1, 3, reset, bus_b.cs, bus_b.we, bus_b.addr, bus_b.din,
                 {24'h0, gpio_b_i});
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("dout_a", {24'h0, bus_a.dout}, {24'h0, m_dout[0]});
            chk("irq_a", {31'h0, bus_a.irq}, {31'h0, m_irq[0]});
            chk("gpio_o_a", gpio_a_o, pack_out(0, 4));
            chk("gpio_oe_a", gpio_a_oe, pack_dir(0, 4));
            chk("dout_b", {24'h0, bus_b.dout}, {24'h0, m_dout[1]});
            chk("irq_b", {31'h0, bus_b.irq}, {31'h0, m_irq[1]});
            chk("gpio_o_b", {24'h0, gpio_b_o}, pack_out(1, 1));
            chk("gpio_oe_b", {24'h0, gpio_b_oe}, pack_dir(1, 1));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wr_a(input logic [4:0] a, input logic [7:0] d);
        bus_a.cs = 1'b1; bus_a.we = 1'b1; bus_a.addr = a; bus_a.din = d;
        @(negedge clk);
        bus_a.cs = 1'b0; bus_a.we = 1'b0;
    endtask

    task automatic rd_a(input logic [4:0] a);
        bus_a.cs = 1'b1; bus_a.we = 1'b0; bus_a.addr = a;
        @(negedge clk);
        bus_a.cs = 1'b0;
    endtask

    task automatic wr_b(input logic [4:0] a, input logic [7:0] d);
        bus_b.cs = 1'b1; bus_b.we = 1'b1; bus_b.addr = a; bus_b.din = d;
        @(negedge clk);
        bus_b.cs = 1'b0; bus_b.we = 1'b0;
    endtask

    task automatic rd_b(input logic [4:0] a);
        bus_b.cs = 1'b1; bus_b.we = 1'b0; bus_b.addr = a;
        @(negedge clk);
        bus_b.cs = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        started = 1'b0;
        reset = 1'b0;
        gpio_a_i = 32'hFFFF_FFFF;
        gpio_b_i = 8'hFF;
        bus_a.cs = 1'b1; bus_a.we = 1'b1; bus_a.addr = 5'h00; bus_a.din = 8'hFF;
        bus_b.cs = 1'b1; bus_b.we = 1'b1; bus_b.addr = 5'h00; bus_b.din = 8'hFF;
        cyc();
        cyc();
        chk("rst_gpio_o_a", gpio_a_o, 32'h0);
        chk("rst_gpio_oe_a", gpio_a_oe, 32'h0);
        chk("rst_dout_a", {24'h0, bus_a.dout}, 32'h0);
        chk("rst_irq_a", {31'h0, bus_a.irq}, 32'h0);
        chk("rst_gpio_o_b", {24'h0, gpio_b_o}, 32'h0);
        chk("rst_dout_b", {24'h0, bus_b.dout}, 32'h0);

        reset = 1'b1;
        bus_a.cs = 1'b0; bus_a.we = 1'b0;
        bus_b.cs = 1'b0; bus_b.we = 1'b0;
        repeat (4) cyc();
        for (int p = 0; p < 4; p++) begin
            rd_a({2'(p), 3'd5});
            chk("rst_flags_a", {24'h0, bus_a.dout}, 32'h0);
        end
        chk("rst_irq_hold", {31'h0, bus_a.irq}, 32'h0);
        gpio_a_i = 32'h0;
        gpio_b_i = 8'h00;
        repeat (4) cyc();

        wr_a(5'h00, 8'hA5);
        chk("out_write", gpio_a_o[7:0], 32'hA5);
        wr_a(5'h06, 8'h0A);
        chk("out_set", gpio_a_o[7:0], 32'hAF);
        wr_a(5'h07, 8'h81);
        chk("out_clr", gpio_a_o[7:0], 32'h2E);
        rd_a(5'h00);
        chk("out_read", {24'h0, bus_a.dout}, 32'h2E);

        wr_a({2'd1, 3'd3}, 8'h01);
        gpio_a_i[8] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk("rise_irq_time", {31'h0, bus_a.irq}, (k == 4) ? 32'h1 : 32'h0);
        end
        rd_a({2'd1, 3'd5});
        chk("rise_flags", {24'h0, bus_a.dout}, 32'h01);
        wr_a({2'd1, 3'd5}, 8'h01);
        chk("clr_irq_hold", {31'h0, bus_a.irq}, 32'h1);
        cyc();
        chk("clr_irq_drop", {31'h0, bus_a.irq}, 32'h0);

        gpio_a_i[23] = 1'b1;
        repeat (4) cyc();
        wr_a({2'd2, 3'd4}, 8'h80);
        gpio_a_i[23] = 1'b0;
        cyc();
        cyc();
        wr_a({2'd2, 3'd5}, 8'h80);
        cyc();
        chk("collide_irq", {31'h0, bus_a.irq}, 32'h1);
        rd_a({2'd2, 3'd5});
        chk("collide_flags", {24'h0, bus_a.dout}, 32'h80);
        chk("collide_irq2", {31'h0, bus_a.irq}, 32'h1);
        wr_a({2'd2, 3'd5}, 8'h80);
        repeat (2) cyc();

        wr_a({2'd3, 3'd1}, 8'hF0);
        chk("dir_oe", gpio_a_oe[31:24], 32'hF0);
        gpio_a_i[31:24] = 8'h5A;
        repeat (3) cyc();
        rd_a({2'd3, 3'd2});
        chk("dir_in", {24'h0, bus_a.dout}, 32'h5A);

        wr_b(5'h00, 8'h3C);
        wr_b(5'h08, 8'hFF);
        chk("b_oob_write", {24'h0, gpio_b_o}, 32'h3C);
        rd_b(5'h00);
        chk("b_out_read", {24'h0, bus_b.dout}, 32'h3C);
        rd_b(5'h08);
        chk("b_oob_read", {24'h0, bus_b.dout}, 32'h00);
        gpio_b_i = 8'h77;
        bus_b.cs = 1'b1; bus_b.we = 1'b0; bus_b.addr = 5'h02;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk("b_in_latency", {24'h0, bus_b.dout}, (k == 4) ? 32'h77 : 32'h00);
        end
        bus_b.cs = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            bus_a.cs   = 1'($urandom_range(0, 1));
            bus_a.we   = 1'($urandom_range(0, 1));
            bus_a.addr = 5'($urandom);
            bus_a.din  = 8'($urandom);
            bus_b.cs   = 1'($urandom_range(0, 1));
            bus_b.we   = 1'($urandom_range(0, 1));
            bus_b.addr = 5'($urandom);
            bus_b.din  = 8'($urandom);
            gpio_a_i   = gpio_a_i ^ ($urandom & $urandom & $urandom);
            gpio_b_i   = gpio_b_i ^ 8'($urandom & $urandom & $urandom);
            cyc();
        end
        bus_a.cs = 1'b0;
        bus_b.cs = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
